// File: rtl/relu_scan.sv
// Activation scanner: walks idx 0..N-1 over the FC1 result mux, applies ReLU and streams beats.
// Define RELU_CLIP_EN to bound each activation to CLIP_MAX.
module relu_scan #(
    parameter int N        = 32,
    parameter int W        = 32,
    parameter int IDXW     = 5,
    parameter int CLIP_MAX = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic [IDXW-1:0] idx,
    input  logic [W-1:0]    din,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic            done,
    output logic [IDXW:0]   pos_count
);

    // valid/ready: a beat transfers on any rising edge where out_valid and out_ready
    // are both high; while out_valid=1 and out_ready=0 the beat holds stable.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_t        state;
    state_t        state_next;
    logic          capture;
    logic          drain_hs;
    logic          din_pos;
    logic [W-1:0]  relu_val;

    assign busy    = (state != IDLE);
    assign din_pos = !din[W-1] && (din != '0);

`ifdef RELU_CLIP_EN
    localparam logic [W-1:0] CLIP_W = W'(CLIP_MAX);

    always_comb begin
        relu_val = '0;
        if (din_pos) begin
            if ($signed(din) > $signed(CLIP_W)) relu_val = CLIP_W;
            else                                relu_val = din;
        end
    end
`else
    logic [31:0] clip_max_unused;
    assign clip_max_unused = CLIP_MAX;

    always_comb begin
        relu_val = '0;
        if (din_pos) relu_val = din;
    end
`endif

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        drain_hs   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SCAN;
            end
            SCAN: begin
                // Single output register: only load when it is empty or being drained.
                if (!out_valid || out_ready) begin
                    capture = 1'b1;
                    if (idx == LAST_IDX) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    drain_hs   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            pos_count <= '0;
        end else begin
            done <= drain_hs;
            if (state == IDLE && start) begin
                pos_count <= '0;
                idx       <= '0;
            end
            if (capture) begin
                out_data  <= relu_val;
                out_idx   <= idx;
                out_last  <= (idx == LAST_IDX);
                out_valid <= 1'b1;
                if (din_pos) pos_count <= pos_count + 1'b1;
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_relu_scan.sv
// Scoreboard bench for relu_scan: expected beats queued at start, popped on each handshake.
module tb_relu_scan;

    localparam int N        = 32;
    localparam int W        = 32;
    localparam int IDXW     = 5;
    localparam int CLIP_MAX = 255;
    localparam int BW       = 1 + IDXW + W;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy;
    logic [IDXW-1:0] idx;
    logic [W-1:0]    din;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [W-1:0]    out_data;
    logic [IDXW-1:0] out_idx;
    logic            out_last;
    logic            done;
    logic [IDXW:0]   pos_count;

    logic [W-1:0]    rom [N];
    logic [BW-1:0]   exp_q [$];
    logic [BW-1:0]   beat;

    int vectors     = 0;
    int miscompares = 0;
    int stalls      = 0;
    int done_seen   = 0;
    int pos_exp     = 0;
    int ready_mode  = 0;
    int tick        = 0;

    logic            held_valid = 1'b0;
    logic [W-1:0]    held_data;
    logic [IDXW-1:0] held_idx;

    relu_scan #(.N(N), .W(W), .IDXW(IDXW), .CLIP_MAX(CLIP_MAX)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .idx(idx), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .done(done), .pos_count(pos_count)
    );

    always #5 clk = ~clk;

    // FC1 result mux model: combinational from idx.
    assign din = rom[idx];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_relu(input logic signed [W-1:0] x);
        if (x <= 0) return '0;
`ifdef RELU_CLIP_EN
        if (x > CLIP_MAX) return W'(CLIP_MAX);
`endif
        return x;
    endfunction

    task automatic queue_pass();
        pos_exp = 0;
        stalls  = 0;
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({(i == N - 1), IDXW'(i), model_relu(rom[i])});
            if ($signed(rom[i]) > 0) pos_exp++;
        end
    endtask

    always @(posedge clk) begin
        #1;
        tick++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (tick % 3 != 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(held_data));
                check("stall_idx", 64'(out_idx), 64'(held_idx));
            end
            held_valid = (out_valid === 1'b1) && !out_ready;
            held_data  = out_data;
            held_idx   = out_idx;
            if (out_valid === 1'b1 && !out_ready) stalls++;
            if (out_valid === 1'b1 && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    beat = exp_q.pop_front();
                    check("beat_data", 64'(out_data), 64'(beat[W-1:0]));
                    check("beat_idx", 64'(out_idx), 64'(beat[W+IDXW-1:W]));
                    check("beat_last", 64'(out_last), 64'(beat[BW-1]));
                end
            end
            if (done === 1'b1) done_seen++;
        end
    end

    task automatic run_pass(input int mid_idx, input bit pre_started, input bit chain_out);
        int cyc;
        bit fired;
        bit got_done;
        fired    = 1'b0;
        got_done = 1'b0;
        if (!pre_started) begin
            @(posedge clk); #1;
            queue_pass();
            start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        cyc = 1;
        check("busy_c1", 64'(busy), 64'd1);
        check("idx_c1", 64'(idx), 64'd0);
        check("pos_c1", 64'(pos_count), 64'd0);
        while (!got_done && cyc < 300) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
                check("done_cycle", 64'(cyc), 64'(N + 2 + stalls));
                check("pos_count", 64'(pos_count), 64'(pos_exp));
                check("busy_done", 64'(busy), 64'd0);
                check("valid_done", 64'(out_valid), 64'd0);
                if (chain_out) begin
                    queue_pass();
                    start = 1'b1;
                end
            end else begin
                if (mid_idx >= 0 && !fired && idx == IDXW'(mid_idx)) begin
                    start = 1'b1;
                    fired = 1'b1;
                end
                @(posedge clk); #1;
                start = 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
        if (!got_done) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int k;
        int ds;
        for (int i = 0; i < N; i++) rom[i] = W'(i - 16);

        rst   = 1'b1;
        start = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_valid", 64'(out_valid), 64'd0);
            check("rst_idx", 64'(idx), 64'd0);
            check("rst_data", 64'(out_data), 64'd0);
            check("rst_outidx", 64'({out_idx, out_last}), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_pos", 64'(pos_count), 64'd0);
        end
        rst   = 1'b0;
        start = 1'b0;

        ready_mode = 0;
        run_pass(-1, 1'b0, 1'b0);
        ready_mode = 1;
        run_pass(-1, 1'b0, 1'b0);
        ready_mode = 0;
        run_pass(7, 1'b0, 1'b1);
        run_pass(-1, 1'b1, 1'b0);

        // Reset in the middle of a pass.
        @(posedge clk); #1;
        queue_pass();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        k = 0;
        while (idx != IDXW'(10) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reach_idx10", 64'(idx), 64'd10);
        rst = 1'b1;
        exp_q.delete();
        ds = done_seen;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_idx", 64'(idx), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_pos", 64'(pos_count), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        repeat (40) @(negedge clk);
        check("no_done_after_rst", 64'(done_seen), 64'(ds));
        check("idle_after_rst", 64'(out_valid), 64'd0);

        // Boundary words plus random fill, random backpressure.
        rom[0] = 32'h7FFF_FFFF;
        rom[1] = 32'd300;
        rom[2] = 32'd255;
        rom[3] = 32'hFFFF_FFFF;
        rom[4] = 32'h8000_0000;
        rom[5] = 32'd1;
        for (int i = 6; i < N; i++) rom[i] = $urandom;
        ready_mode = 2;
        run_pass(-1, 1'b0, 1'b0);
        ready_mode = 0;

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
